apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Sequencing controller that shares one APB4 master port among `NUM_REQ` local requesters. Arbitration is round-robin. The block drives the IDLE/SETUP/ACCESS protocol on the master side of the APB interface, handles PREADY wait states with a timeout, and returns read data and error status to the granted requester. It sits between on-chip command sources and the APB bus, on the master side.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: APB address width.
- `DATA_WIDTH`, default 32: APB data width. Must be 8, 16 or 32.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 16: maximum consecutive ACCESS cycles with PREADY low. 0 disables the timeout.

Ports:
- `PCLK` in 1: the single clock.
- `PRESET` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: one-hot, combinational. Acceptance occurs when the `req_valid[i]` and `req_ready[i]` bits are both high.
- `req_write` in NUM_REQ: per-requester write(1)/read(0).
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed per-requester address. Requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `req_strb` in NUM_REQ*DATA_WIDTH/8: packed write strobes.
- `req_prot` in NUM_REQ*3: packed PPROT values.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse to the owning requester.
- `rsp_rdata` out DATA_WIDTH: read data, valid with `rsp_valid`. Equals 0 for writes and for timeouts.
- `rsp_err` out 1: error status, valid with `rsp_valid`. Equals PSLVERR, or 1 on timeout.
- `PADDR` out ADDR_WIDTH, `PPROT` out 3, `PNSE` out 1 (tied 0), `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out DATA_WIDTH, `PSTRB` out DATA_WIDTH/8: APB request signals.
- `PREADY` in 1, `PRDATA` in DATA_WIDTH, `PSLVERR` in 1: APB completer response.
- `PWAKEUP` out 1: high while any `req_valid` bit is set or the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- An acceptance point is either a cycle in IDLE, or an ACCESS cycle in which the transfer completes.
  - At an acceptance point with any `req_valid` high, the arbiter asserts `req_ready` for exactly one winner.
  - The winner's fields are registered into the command register, and the next state is SETUP.
  - If no `req_valid` bit is high, the next state is IDLE.
- SETUP: PSEL=1, PENABLE=0. The next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - Completion occurs when PREADY=1.
  - A timeout occurs when PREADY has been 0 for TIMEOUT consecutive ACCESS cycles. The transfer is terminated after that cycle, with `rsp_err`=1 and `rsp_rdata`=0.
  - If PREADY=1 in the same cycle the timeout would fire, PREADY wins and the transfer completes normally.
- Round-robin arbitration:
  - The pointer `last` holds the last winner.
  - The search starts at `last`+1 modulo NUM_REQ.
  - `last` updates only on acceptance.
  - After reset, `last`=NUM_REQ-1, so requester 0 has first priority.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are driven from the command register and stay stable from SETUP through the end of ACCESS.
  - PSTRB is forced to 0 on reads.
  - Between transfers these signals hold their last value.
- Response: `rsp_valid[owner]` pulses in the cycle after completion or timeout.
  - `rsp_rdata` captures PRDATA on a read completion.
  - `rsp_err` captures PSLVERR, masked by completion.
- The response pulse and a new acceptance may occur in the same cycle.
- A requester must hold its `req_*` fields stable while `req_valid` is high and the request has not been accepted.

## Timing
- Reset values:
  - All outputs are 0, apart from the combinational `req_ready` and `PWAKEUP`, which still follow their definitions.
  - The state is IDLE, the timeout counter is 0 and `last`=NUM_REQ-1.
- Reset is asserted asynchronously and takes effect immediately, mid-transfer included. PSEL and PENABLE drop, the transfer is abandoned, and no `rsp_valid` is issued. Reset is deasserted synchronously to PCLK.
- Zero-wait-state latency:
  - Cycle 0: acceptance in IDLE.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, with PREADY=1.
  - Cycle 3: `rsp_valid`.
- Each PREADY-low cycle adds one cycle of latency.
- Back-to-back: the transfer that completes in cycle N is followed by SETUP in cycle N+1, with no IDLE cycle in between. Sustained throughput is one transfer per 2 cycles.
- Timeout counter: clears on entry to ACCESS, increments on each ACCESS cycle with PREADY=0, and saturates.

## Structure
- Shared package `apb_ctrl_pkg` contains:
  - the `apb_state_e` enum {IDLE, SETUP, ACCESS};
  - the PPROT bit constants (privileged, nonsecure, instruction).
- The sub-module `rr_arbiter` (parameter N) takes the request vector, the `last` pointer and an enable input. It outputs a one-hot grant and the encoded winner index.
- All other logic (FSM, command register, timeout counter and response registers) lives in the top module.

## Test plan
- **Single write:** requester 2 writes address 0x10, data 0xDEADBEEF, strobe 0xF, with PREADY=1. Required: PSEL in cycle 1, PENABLE in cycle 2, `rsp_valid`=0b0100 in cycle 3, `rsp_err`=0.
- **Read with wait states:** requester 0 reads 0x40 and PREADY is held low for 3 cycles, with PRDATA=0x12345678. Required: ACCESS lasts 4 cycles, `rsp_rdata`=0x12345678, PADDR stable throughout, PSTRB=0.
- **Round-robin:** all 4 requesters hold `req_valid` continuously. Required: grant order 0,1,2,3,0, back-to-back with no IDLE cycles.
- **Timeout:** with TIMEOUT=16, PREADY is held low. Required: after 16 ACCESS cycles PSEL drops, and `rsp_err`=1 with `rsp_rdata`=0. A separate case raises PREADY on the 16th cycle; required: normal completion with `rsp_err`=PSLVERR.
- **Slave error:** PSLVERR=1 with PREADY=1 on a write. Required: `rsp_err`=1.
- **Mid-transfer reset:** PRESET is pulled low during ACCESS. Required: all outputs drop to 0 immediately and no `rsp_valid` is issued. After release, requester 0 has first priority.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: types and constants shared by the APB master controller.
// Holds the bus FSM state encoding and the PPROT bit positions.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among N requests, starting after `last`.
// Produces a one-hot grant and the encoded winner; silent when disabled.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Scan last+1 .. last+N (mod N) and keep the first pending request.
    always_comb begin
        logic [IW-1:0] k;
        logic          found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last) + i) % N);
            if (en && !found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: shares one APB4 master port among NUM_REQ requesters.
// Round-robin arbitration, PREADY timeout, per-requester response pulse.
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]            req_prot,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [2:0]                      PPROT,
    output logic                            PNSE,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic                            PREADY,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PSLVERR,
    output logic                            PWAKEUP
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IW     = $clog2(NUM_REQ);
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e    state;
    apb_state_e    state_nxt;
    logic [IW-1:0] last;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] owner;
    logic [CW-1:0] to_cnt;
    logic          complete;
    logic          timeout;
    logic          accept_pt;
    logic          accept;

    // A transfer ends either on PREADY or on the wait-state limit.
    assign complete  = (state == ACCESS) && PREADY;
    assign timeout   = (TIMEOUT != 0) && (state == ACCESS) && !PREADY
                       && (to_cnt == CW'(TIMEOUT - 1));
    assign accept_pt = (state == IDLE) || complete;
    assign accept    = accept_pt && (|req_valid);

    assign PSEL    = (state != IDLE);
    assign PENABLE = (state == ACCESS);
    assign PNSE    = 1'b0;
    assign PWAKEUP = (|req_valid) || (state != IDLE);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .last (last),
        .en   (accept_pt),
        .gnt  (req_ready),
        .idx  (win_idx)
    );

    // Next-state decode; a completing ACCESS may chain straight into SETUP.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = accept ? SETUP : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (complete)
                    state_nxt = accept ? SETUP : IDLE;
                else if (timeout)
                    state_nxt = IDLE;
                else
                    state_nxt = ACCESS;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Wait-state counter: cleared in SETUP, counts PREADY-low ACCESS cycles.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            to_cnt <= '0;
        else if (state == SETUP)
            to_cnt <= '0;
        else if ((state == ACCESS) && !PREADY && (to_cnt != CW'(TIMEOUT)))
            to_cnt <= to_cnt + CW'(1);
    end

    // Command register and round-robin pointer, loaded on acceptance.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            last   <= IW'(NUM_REQ - 1);
            owner  <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
            PPROT  <= '0;
        end else if (accept) begin
            last   <= win_idx;
            owner  <= win_idx;
            PADDR  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            PWRITE <= req_write[win_idx];
            PWDATA <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            PSTRB  <= req_write[win_idx]
                      ? req_strb[win_idx*STRB_W +: STRB_W] : '0;
            PPROT  <= req_prot[win_idx*3 +: 3];
        end
    end

    // Response pulse to the owner one cycle after completion or timeout.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (complete || timeout) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_rdata <= (complete && !PWRITE) ? PRDATA : '0;
                rsp_err   <= (complete && PSLVERR) || timeout;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin / APB timing model.
module tb_apb_master_ctrl;
    import apb_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 16;
    localparam int SW = DW / 8;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [NR-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_strb;
    logic [NR*3-1:0]  req_prot;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   PADDR;
    logic [2:0]      PPROT;
    logic            PNSE, PSEL, PENABLE, PWRITE, PWAKEUP;
    logic [DW-1:0]   PWDATA, PRDATA;
    logic [SW-1:0]   PSTRB;
    logic            PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] f_addr  [NR];
    logic [DW-1:0] f_wdata [NR];
    logic [SW-1:0] f_strb  [NR];
    logic [2:0]    f_prot  [NR];

    apb_master_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PPROT     (PPROT),
        .PNSE      (PNSE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .PWAKEUP   (PWAKEUP)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_fields();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = f_addr[i];
            req_wdata[i*DW +: DW] = f_wdata[i];
            req_strb[i*SW +: SW]  = f_strb[i];
            req_prot[i*3 +: 3]    = f_prot[i];
        end
    endtask

    task automatic set_req(input int idx, input logic wr,
                           input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb,
                           input logic [2:0] prot);
        req_write[idx] = wr;
        f_addr[idx]    = addr;
        f_wdata[idx]   = wdata;
        f_strb[idx]    = strb;
        f_prot[idx]    = prot;
        drive_fields();
    endtask

    task automatic do_reset();
        PRESET    = 1'b0;
        req_valid = '0;
        req_write = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0, '0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
    endtask

    // One isolated transfer from IDLE; returns what the bus showed.
    task automatic xfer(input int idx, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input int ready_at,
                        input logic slverr, input logic [DW-1:0] prdata,
                        output int n_acc, output logic stable,
                        output logic [SW-1:0] strb_seen,
                        output logic [NR-1:0] rv, output logic [DW-1:0] rd,
                        output logic re, output logic psel_after);
        @(negedge PCLK);
        set_req(idx, wr, addr, wdata, strb, 3'b000);
        req_valid = NR'(1) << idx;
        PREADY    = 1'b0;
        PSLVERR   = slverr;
        PRDATA    = prdata;
        @(negedge PCLK);
        req_valid = '0;
        stable    = (PSEL === 1'b1) && (PENABLE === 1'b0) && (PADDR === addr);
        strb_seen = PSTRB;
        n_acc     = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1) break;
            n_acc++;
            if (PADDR !== addr || PSEL !== 1'b1) stable = 1'b0;
            strb_seen = strb_seen | PSTRB;
            PREADY = (n_acc == ready_at);
        end
        rv         = rsp_valid;
        rd         = rsp_rdata;
        re         = rsp_err;
        psel_after = PSEL;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PNSE, PADDR, PWDATA, PSTRB, PPROT,
             rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rsp_valid=%b, want all 0",
                     PSEL, PENABLE, PADDR, rsp_valid);
        end
        checks++;
        if ({req_ready, PWAKEUP} !== '0) begin
            errors++;
            $display("FAIL reset_idle_ready: got ready=%b wake=%b, want 0 0", req_ready, PWAKEUP);
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL reset_priority: got %b want 0010", req_ready);
        end
        checks++;
        if (PWAKEUP !== 1'b1) begin
            errors++;
            $display("FAIL reset_wakeup: got %b want 1", PWAKEUP);
        end
        req_valid = '0;
    endtask

    task automatic test_single_write();
        logic [2:0] prot;
        prot = 3'(1 << PPROT_NONSEC);
        @(negedge PCLK);
        set_req(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, prot);
        req_valid = 4'b0100;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL sw_ready: got %b want 0100", req_ready);
        end
        @(negedge PCLK);
        req_valid = '0;
        checks++;
        if ({PSEL, PENABLE} !== 2'b10) begin
            errors++;
            $display("FAIL sw_setup: got psel/pen=%b want 10", {PSEL, PENABLE});
        end
        checks++;
        if ({PADDR, PWDATA, PSTRB, PWRITE, PPROT} !==
            {32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, prot}) begin
            errors++;
            $display("FAIL sw_cmd: got %h %h %h %b %b want 10 deadbeef f 1 %b",
                     PADDR, PWDATA, PSTRB, PWRITE, PPROT, prot);
        end
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== {2'b11, 4'b0000}) begin
            errors++;
            $display("FAIL sw_access: got psel/pen=%b rsp=%b want 11 0000",
                     {PSEL, PENABLE}, rsp_valid);
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, rsp_err, PSEL, PENABLE} !== {4'b0100, 3'b000}) begin
            errors++;
            $display("FAIL sw_rsp: got rsp=%b err=%b psel/pen=%b want 0100 0 00",
                     rsp_valid, rsp_err, {PSEL, PENABLE});
        end
        PREADY = 1'b0;
    endtask

    task automatic test_read_wait();
        int n; logic st, re, ps; logic [SW-1:0] sb; logic [NR-1:0] rv; logic [DW-1:0] rd;
        xfer(0, 1'b0, 32'h40, $urandom, 4'hF, 4, 1'b0, 32'h1234_5678,
             n, st, sb, rv, rd, re, ps);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rw_access_len: got %0d want 4", n);
        end
        checks++;
        if ({st, sb} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL rw_addr_strb: got stable=%b strb=%h want 1 0", st, sb);
        end
        checks++;
        if ({rv, rd, re} !== {4'b0001, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL rw_rsp: got %b %h %b want 0001 12345678 0", rv, rd, re);
        end
    endtask

    task automatic test_timeout();
        int n; logic st, re, ps; logic [SW-1:0] sb; logic [NR-1:0] rv; logic [DW-1:0] rd;
        xfer(3, 1'b0, 32'h800, '0, '0, 0, 1'b0, 32'hFFFF_FFFF,
             n, st, sb, rv, rd, re, ps);
        checks++;
        if (n != TO || ps !== 1'b0) begin
            errors++;
            $display("FAIL to_len: got %0d cycles psel_after=%b want %0d 0", n, ps, TO);
        end
        checks++;
        if ({rv, rd, re} !== {4'b1000, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL to_rsp: got %b %h %b want 1000 00000000 1", rv, rd, re);
        end
        xfer(1, 1'b0, 32'h804, '0, '0, TO, 1'b0, 32'hA5A5_5A5A,
             n, st, sb, rv, rd, re, ps);
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL to_edge_len: got %0d want %0d", n, TO);
        end
        checks++;
        if ({rv, rd, re} !== {4'b0010, 32'hA5A5_5A5A, 1'b0}) begin
            errors++;
            $display("FAIL to_edge_rsp: got %b %h %b want 0010 a5a55a5a 0", rv, rd, re);
        end
    endtask

    task automatic test_slave_error();
        int n; logic st, re, ps; logic [SW-1:0] sb; logic [NR-1:0] rv; logic [DW-1:0] rd;
        xfer(2, 1'b1, 32'h123C, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h5555_AAAA,
             n, st, sb, rv, rd, re, ps);
        checks++;
        if (n != 1 || sb !== 4'h3) begin
            errors++;
            $display("FAIL se_len: got %0d strb=%h want 1 3", n, sb);
        end
        checks++;
        if ({rv, rd, re} !== {4'b0100, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL se_rsp: got %b %h %b want 0100 00000000 1", rv, rd, re);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b0, 32'h100 + 32'(i * 4), '0, 4'hF, 3'b000);
        @(negedge PCLK);
        req_valid = '1;
        PREADY    = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_grant0: got %b want 0001", req_ready);
        end
        for (int k = 1; k <= NR; k++) begin
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE} !== 2'b10) begin
                errors++;
                $display("FAIL rr_setup%0d: got %b want 10", k, {PSEL, PENABLE});
            end
            @(negedge PCLK);
            #1;
            checks++;
            if ({PSEL, PENABLE, req_ready} !== {2'b11, NR'(1) << (k % NR)}) begin
                errors++;
                $display("FAIL rr_grant%0d: got psel/pen=%b ready=%b want 11 %b",
                         k, {PSEL, PENABLE}, req_ready, NR'(1) << (k % NR));
            end
        end
        @(negedge PCLK);
        req_valid = '0;
        repeat (3) @(negedge PCLK);
        PREADY = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [NR-1:0] seen;
        @(negedge PCLK);
        set_req(1, 1'b1, 32'hCAFE_0000, 32'h1111_2222, 4'hF, 3'b101);
        req_valid = 4'b0010;
        PREADY    = 1'b0;
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        checks++;
        if (PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL mr_in_access: got %b want 1", PENABLE);
        end
        #2 PRESET = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid,
             rsp_rdata, rsp_err, PWAKEUP, req_ready} !== '0) begin
            errors++;
            $display("FAIL mr_outputs: got psel=%b pen=%b paddr=%h wake=%b, want all 0",
                     PSEL, PENABLE, PADDR, PWAKEUP);
        end
        PREADY = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        seen = '0;
        repeat (3) begin
            @(negedge PCLK);
            seen = seen | rsp_valid;
        end
        checks++;
        if ({seen, PSEL} !== '0) begin
            errors++;
            $display("FAIL mr_no_rsp: got rsp=%b psel=%b want 0000 0", seen, PSEL);
        end
        PREADY    = 1'b0;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mr_priority: got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_random(input int ntx);
        logic [NR-1:0] pend, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rd;
        logic [SW-1:0] e_strb;
        logic [2:0]    e_prot;
        logic          e_write, e_re, rsp_due, acc_pt, rdy, wake;
        int phase, k, wait_n, done, owner, lastm, clr, win;
        do_reset();
        pend = '0; phase = 0; done = 0; lastm = NR - 1; clr = -1;
        rsp_due = 1'b0; k = 0; wait_n = 0; owner = 0;
        e_rv = '0; e_rd = '0; e_re = 1'b0;
        e_addr = '0; e_wdata = '0; e_strb = '0; e_prot = '0; e_write = 1'b0;
        for (int cyc = 0; cyc < 4000 && done < ntx; cyc++) begin
            @(negedge PCLK);
            checks++;
            if (rsp_due) begin
                if ({rsp_valid, rsp_rdata, rsp_err} !== {e_rv, e_rd, e_re}) begin
                    errors++;
                    $display("FAIL rnd_rsp: got %b %h %b want %b %h %b",
                             rsp_valid, rsp_rdata, rsp_err, e_rv, e_rd, e_re);
                end
            end else if (rsp_valid !== '0) begin
                errors++;
                $display("FAIL rnd_spurious_rsp: got %b want 0000", rsp_valid);
            end
            rsp_due = 1'b0;
            if (clr >= 0) pend[clr] = 1'b0;
            clr = -1;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
                            SW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                end
            end
            req_valid = pend;
            wake   = (pend != '0) || (phase != 0);
            acc_pt = 1'b0;
            PREADY = 1'b0;
            case (phase)
                0: begin
                    checks++;
                    if ({PSEL, PENABLE} !== 2'b00) begin
                        errors++;
                        $display("FAIL rnd_idle: got %b want 00", {PSEL, PENABLE});
                    end
                    acc_pt = 1'b1;
                end
                1: begin
                    checks++;
                    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT} !==
                        {2'b10, e_addr, e_write, e_wdata, e_strb, e_prot}) begin
                        errors++;
                        $display("FAIL rnd_setup: got %b %h %b %h %h %b want 10 %h %b %h %h %b",
                                 {PSEL, PENABLE}, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
                                 e_addr, e_write, e_wdata, e_strb, e_prot);
                    end
                    phase = 2;
                    k = 0;
                end
                default: begin
                    checks++;
                    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT} !==
                        {2'b11, e_addr, e_write, e_wdata, e_strb, e_prot}) begin
                        errors++;
                        $display("FAIL rnd_access: got %b %h %b %h %h %b want 11 %h %b %h %h %b",
                                 {PSEL, PENABLE}, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
                                 e_addr, e_write, e_wdata, e_strb, e_prot);
                    end
                    rdy     = (k == wait_n);
                    PREADY  = rdy;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom_range(0, 1));
                    if (rdy) begin
                        rsp_due = 1'b1;
                        e_rv    = NR'(1) << owner;
                        e_rd    = e_write ? '0 : PRDATA;
                        e_re    = PSLVERR;
                        acc_pt  = 1'b1;
                        done++;
                        phase   = 0;
                    end else if (k == TO - 1) begin
                        rsp_due = 1'b1;
                        e_rv    = NR'(1) << owner;
                        e_rd    = '0;
                        e_re    = 1'b1;
                        done++;
                        phase   = 0;
                    end else begin
                        k++;
                    end
                end
            endcase
            #1;
            checks++;
            if (PWAKEUP !== wake) begin
                errors++;
                $display("FAIL rnd_wakeup: got %b want %b", PWAKEUP, wake);
            end
            if (acc_pt && pend != '0) begin
                win = -1;
                for (int j = 1; j <= NR; j++)
                    if (win < 0 && pend[(lastm + j) % NR]) win = (lastm + j) % NR;
                checks++;
                if (req_ready !== NR'(1) << win) begin
                    errors++;
                    $display("FAIL rnd_grant: got %b want %b", req_ready, NR'(1) << win);
                end
                owner   = win;
                lastm   = win;
                clr     = win;
                e_addr  = f_addr[win];
                e_write = req_write[win];
                e_wdata = f_wdata[win];
                e_strb  = req_write[win] ? f_strb[win] : '0;
                e_prot  = f_prot[win];
                phase   = 1;
                case ($urandom_range(0, 6))
                    5:       wait_n = TO - 1;
                    6:       wait_n = 1000;
                    default: wait_n = $urandom_range(0, 4);
                endcase
            end else begin
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL rnd_nogrant: got %b want 0000", req_ready);
                end
            end
        end
        checks++;
        if (done < ntx) begin
            errors++;
            $display("FAIL rnd_budget: got %0d transfers want %0d", done, ntx);
        end
        @(negedge PCLK);
        req_valid = '0;
        PREADY    = 1'b1;
        repeat (4) @(negedge PCLK);
        PREADY    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_timeout();
        test_slave_error();
        test_round_robin();
        test_mid_reset();
        test_random(80);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
